// File: rtl/minesweeper_pkg.sv
// Shared types and helpers for the minesweeper board logic.
package minesweeper_pkg;

    localparam int GRID_DIM  = 8;
    localparam int CELL_BITS = 4;
    localparam int NUM_CELLS = GRID_DIM * GRID_DIM;

    localparam logic [CELL_BITS-1:0] MINE_VAL = 4'h9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAY,
        ST_POP,
        ST_NBR,
        ST_LOST,
        ST_WON
    } state_t;

    // Row/column offsets held as 2-bit two's complement (-1, 0, +1).
    typedef struct packed {
        logic [1:0] dr;
        logic [1:0] dc;
    } nbr_off_t;

    function automatic logic [5:0] cell_idx(input logic [2:0] r, input logic [2:0] c);
        return {r, c};
    endfunction

    function automatic nbr_off_t nbr_offset(input logic [2:0] n);
        case (n)
            3'd0:    return '{dr: 2'b11, dc: 2'b11};
            3'd1:    return '{dr: 2'b11, dc: 2'b00};
            3'd2:    return '{dr: 2'b11, dc: 2'b01};
            3'd3:    return '{dr: 2'b00, dc: 2'b11};
            3'd4:    return '{dr: 2'b00, dc: 2'b01};
            3'd5:    return '{dr: 2'b01, dc: 2'b11};
            3'd6:    return '{dr: 2'b01, dc: 2'b00};
            default: return '{dr: 2'b01, dc: 2'b01};
        endcase
    endfunction

endpackage

// File: rtl/reveal_engine_if.sv
// Map/request/status bundle between the game controller side and the reveal engine.
interface reveal_engine_if;
    logic         map_load;
    logic [255:0] map_flat;
    logic         click_valid;
    logic         flag_valid;
    logic [2:0]   sel_row;
    logic [2:0]   sel_col;
    logic [255:0] map_out;
    logic [63:0]  revealed;
    logic [63:0]  flagged;
    logic         busy;
    logic         game_lost;
    logic         game_won;

    modport master (
        output map_load, map_flat, click_valid, flag_valid, sel_row, sel_col,
        input  map_out, revealed, flagged, busy, game_lost, game_won
    );

    modport slave (
        input  map_load, map_flat, click_valid, flag_valid, sel_row, sel_col,
        output map_out, revealed, flagged, busy, game_lost, game_won
    );
endinterface

// File: rtl/cell_stack.sv
// 64-entry LIFO of 6-bit cell indices used as the flood-fill work list.
module cell_stack (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       push,
    input  logic       pop,
    input  logic [5:0] din,
    output logic [5:0] top,
    output logic       empty,
    output logic [6:0] count
);
    logic [5:0] mem [64];
    logic [6:0] sp;

    // Stack pointer: clear wins, then push, then pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sp <= '0;
        else if (clr)
            sp <= '0;
        else if (push)
            sp <= sp + 7'd1;
        else if (pop && sp != 7'd0)
            sp <= sp - 7'd1;
    end

    // Storage needs no reset; only the pointer defines validity.
    always_ff @(posedge clk) begin
        if (push && !clr)
            mem[sp[5:0]] <= din;
    end

    assign top   = mem[sp[5:0] - 6'd1];
    assign empty = (sp == 7'd0);
    assign count = sp;
endmodule

// File: rtl/reveal_engine.sv
// Latches the board, services clicks/flags and flood-fills zero regions.
//
// state   | meaning
// --------+----------------------------------------------
// IDLE    | no board loaded, requests ignored
// PLAY    | board loaded, accepting click/flag
// POP     | pop one index per cycle and reveal it
// NBR     | scan the 8 neighbours of a zero cell
// LOST    | mine opened, wait for map_load
// WON     | all safe cells opened, wait for map_load
module reveal_engine
    import minesweeper_pkg::*;
#(
    parameter int NUM_MINES = 10
) (
    input  logic clk,
    input  logic rst,
    reveal_engine_if.slave bus
);
    state_t     state;
    logic [63:0] pending;
    logic [6:0]  revealed_count;
    logic [2:0]  nbr;
    logic [5:0]  cur_idx;

    logic       stk_push, stk_pop;
    logic [5:0] stk_din, stk_top;
    logic       stk_empty;
    logic [6:0] stk_count;
    logic       unused_stk;

    logic [5:0] sel_idx;
    logic [3:0] sel_val, top_val;
    logic       click_ok, click_safe;
    nbr_off_t   off;
    logic [3:0] nbr_r, nbr_c;
    logic [5:0] nbr_idx;
    logic       nbr_push;

    assign unused_stk = ^stk_count;

    cell_stack u_stack (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.map_load),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (stk_din),
        .top   (stk_top),
        .empty (stk_empty),
        .count (stk_count)
    );

    // Request decode, neighbour address generation and stack control.
    always_comb begin
        sel_idx    = cell_idx(bus.sel_row, bus.sel_col);
        sel_val    = bus.map_out[{sel_idx, 2'b00} +: 4];
        top_val    = bus.map_out[{stk_top, 2'b00} +: 4];
        click_ok   = !bus.revealed[sel_idx] && !bus.flagged[sel_idx];
        click_safe = click_ok && (sel_val != MINE_VAL);

        off     = nbr_offset(nbr);
        nbr_r   = {1'b0, cur_idx[5:3]} + {{2{off.dr[1]}}, off.dr};
        nbr_c   = {1'b0, cur_idx[2:0]} + {{2{off.dc[1]}}, off.dc};
        nbr_idx = cell_idx(nbr_r[2:0], nbr_c[2:0]);
        // Out-of-range results (-1 or 8) both have bit 3 set.
        nbr_push = !nbr_r[3] && !nbr_c[3] && !bus.revealed[nbr_idx]
                   && !bus.flagged[nbr_idx] && !pending[nbr_idx];

        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_din  = sel_idx;
        if (!bus.map_load) begin
            case (state)
                ST_PLAY: stk_push = bus.click_valid && click_safe;
                ST_POP:  stk_pop  = !stk_empty;
                ST_NBR: begin
                    stk_push = nbr_push;
                    stk_din  = nbr_idx;
                end
                default: ;
            endcase
        end
    end

    // Main FSM with registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            bus.map_out    <= '0;
            bus.revealed   <= '0;
            bus.flagged    <= '0;
            bus.busy       <= 1'b0;
            bus.game_lost  <= 1'b0;
            bus.game_won   <= 1'b0;
            pending        <= '0;
            revealed_count <= '0;
            nbr            <= '0;
            cur_idx        <= '0;
        end else if (bus.map_load) begin
            state          <= ST_PLAY;
            bus.map_out    <= bus.map_flat;
            bus.revealed   <= '0;
            bus.flagged    <= '0;
            bus.busy       <= 1'b0;
            bus.game_lost  <= 1'b0;
            bus.game_won   <= 1'b0;
            pending        <= '0;
            revealed_count <= '0;
            nbr            <= '0;
            cur_idx        <= '0;
        end else begin
            case (state)
                ST_PLAY: begin
                    if (bus.click_valid) begin
                        if (click_ok && sel_val == MINE_VAL) begin
                            bus.revealed[sel_idx] <= 1'b1;
                            bus.game_lost         <= 1'b1;
                            state                 <= ST_LOST;
                        end else if (click_safe) begin
                            pending[sel_idx] <= 1'b1;
                            bus.busy         <= 1'b1;
                            state            <= ST_POP;
                        end
                    end else if (bus.flag_valid && !bus.revealed[sel_idx]) begin
                        bus.flagged[sel_idx] <= ~bus.flagged[sel_idx];
                    end
                end
                ST_POP: begin
                    if (stk_empty) begin
                        bus.busy <= 1'b0;
                        if (revealed_count == 7'(64 - NUM_MINES)) begin
                            bus.game_won <= 1'b1;
                            state        <= ST_WON;
                        end else begin
                            state <= ST_PLAY;
                        end
                    end else begin
                        bus.revealed[stk_top] <= 1'b1;
                        revealed_count        <= revealed_count + 7'd1;
                        if (top_val == 4'd0) begin
                            cur_idx <= stk_top;
                            nbr     <= '0;
                            state   <= ST_NBR;
                        end
                    end
                end
                ST_NBR: begin
                    if (nbr_push)
                        pending[nbr_idx] <= 1'b1;
                    if (nbr == 3'd7)
                        state <= ST_POP;
                    else
                        nbr <= nbr + 3'd1;
                end
                default: ;
            endcase
        end
    end
endmodule
